// File: rtl/pong_matrix_scanner_if.sv
// Game-logic / LED-pin bundle for the pong matrix scanner.
// The master drives the frame positions; the slave (scanner) drives the matrix pins.
interface pong_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int PW = $clog2(COLS) + 1;
    localparam int BW = $clog2(ROWS) + 1;
    localparam int RW = $clog2(ROWS);

    // frame_load is a one-cycle strobe with no ready: the scanner takes it on
    // every edge where it is high, and the last load before a frame boundary wins.
    logic            frame_load;
    logic [PW-1:0]   p1_pos;
    logic [PW-1:0]   p2_pos;
    logic [BW-1:0]   ball_x;
    logic [PW-1:0]   ball_y;
    logic            blink_en;

    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] red;
    logic [COLS-1:0] green;
    logic [COLS-1:0] blue;
    logic            frame_done;

    logic            dbgScan;
    logic [RW-1:0]   dbgRow;

    modport master (
        output frame_load, p1_pos, p2_pos, ball_x, ball_y, blink_en,
        input  row_sel, red, green, blue, frame_done, dbgScan, dbgRow
    );

    modport slave (
        input  frame_load, p1_pos, p2_pos, ball_x, ball_y, blink_en,
        output row_sel, red, green, blue, frame_done, dbgScan, dbgRow
    );
endinterface

// File: rtl/pong_matrix_scanner.sv
// Double-buffered pong playfield renderer with a row-at-a-time LED matrix scan.
// Paddles blue on rows 0 and ROWS-1, ball red, overlap white; ball can blink.
module pong_matrix_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int PADDLE_W     = 3,
    parameter int DWELL        = 1000,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pong_matrix_scanner_if.slave bus
);
    localparam int PW   = $clog2(COLS) + 1;
    localparam int BW   = $clog2(ROWS) + 1;
    localparam int RW   = $clog2(ROWS);
    localparam int DW   = $clog2(DWELL + 1);
    localparam int KW   = $clog2(2 * BLINK_FRAMES);
    localparam int HALF = PADDLE_W / 2;

    typedef enum logic {BLANK, SCAN} scanState_t;

    scanState_t      state;
    logic [RW-1:0]   rowIdx;
    logic [DW-1:0]   dwellCnt;
    logic [KW-1:0]   blinkCnt;

    logic [PW-1:0]   shP1, shP2, shBy;
    logic [BW-1:0]   shBx;
    logic            shValid;
    logic            pending;

    logic [PW-1:0]   acP1, acP2, acBy;
    logic [BW-1:0]   acBx;
    logic            acValid;

    logic [ROWS-1:0] rowSelQ;
    logic [COLS-1:0] redQ, greenQ, blueQ;
    logic            frameDoneQ;

    logic [COLS-1:0] patRed, patGreen, patBlue;
    logic            ballVisible;
    logic            ballOnRow;
    logic            lastRow;

    assign lastRow     = (rowIdx == RW'(ROWS - 1));
    assign ballVisible = !(bus.blink_en && (int'(blinkCnt) >= BLINK_FRAMES));
    assign ballOnRow   = acValid && ballVisible &&
                         (int'(acBx) < ROWS) && (int'(acBy) < COLS) &&
                         (int'(rowIdx) == int'(acBx));

    // Distances are taken in int so paddles near column 0 clip instead of wrapping.
    always_comb begin
        patBlue = '0;
        patRed  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (acValid && (rowIdx == '0) && (int'(acP1) < COLS) &&
                (c - int'(acP1) <= HALF) && (int'(acP1) - c <= HALF))
                patBlue[c] = 1'b1;
            if (acValid && lastRow && (int'(acP2) < COLS) &&
                (c - int'(acP2) <= HALF) && (int'(acP2) - c <= HALF))
                patBlue[c] = 1'b1;
            if (ballOnRow && (c == int'(acBy)))
                patRed[c] = 1'b1;
        end
        patGreen = patRed & patBlue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            rowIdx     <= '0;
            dwellCnt   <= '0;
            blinkCnt   <= '0;
            shP1       <= '0;
            shP2       <= '0;
            shBx       <= '0;
            shBy       <= '0;
            shValid    <= 1'b0;
            pending    <= 1'b0;
            acP1       <= '0;
            acP2       <= '0;
            acBx       <= '0;
            acBy       <= '0;
            acValid    <= 1'b0;
            rowSelQ    <= '0;
            redQ       <= '0;
            greenQ     <= '0;
            blueQ      <= '0;
            frameDoneQ <= 1'b0;
        end else begin
            frameDoneQ <= 1'b0;
            case (state)
                BLANK: begin
                    state    <= SCAN;
                    dwellCnt <= '0;
                    rowSelQ  <= ROWS'(1) << rowIdx;
                    redQ     <= patRed;
                    greenQ   <= patGreen;
                    blueQ    <= patBlue;
                end
                SCAN: begin
                    if (dwellCnt == DW'(DWELL - 1)) begin
                        state   <= BLANK;
                        rowSelQ <= '0;
                        redQ    <= '0;
                        greenQ  <= '0;
                        blueQ   <= '0;
                        if (lastRow) begin
                            // Frame boundary: the only point where the visible set may change.
                            rowIdx     <= '0;
                            frameDoneQ <= 1'b1;
                            blinkCnt   <= (blinkCnt == KW'(2 * BLINK_FRAMES - 1)) ?
                                          '0 : blinkCnt + KW'(1);
                            if (pending) begin
                                acP1    <= shP1;
                                acP2    <= shP2;
                                acBx    <= shBx;
                                acBy    <= shBy;
                                acValid <= shValid;
                                pending <= 1'b0;
                            end
                        end else begin
                            rowIdx <= rowIdx + RW'(1);
                        end
                    end else begin
                        dwellCnt <= dwellCnt + DW'(1);
                    end
                end
                default: state <= BLANK;
            endcase

            // A load on the boundary edge overrides the pending clear above.
            if (bus.frame_load) begin
                shP1    <= bus.p1_pos;
                shP2    <= bus.p2_pos;
                shBx    <= bus.ball_x;
                shBy    <= bus.ball_y;
                shValid <= 1'b1;
                pending <= 1'b1;
            end
        end
    end

    assign bus.row_sel    = rowSelQ;
    assign bus.red        = redQ;
    assign bus.green      = greenQ;
    assign bus.blue       = blueQ;
    assign bus.frame_done = frameDoneQ;
    assign bus.dbgScan    = (state == SCAN);
    assign bus.dbgRow     = rowIdx;
endmodule

// File: tb/tb_pong_matrix_scanner.sv
// Self-checking bench for pong_matrix_scanner at 8x8, paddle 3, dwell 4, blink 2.
// Expected rows are queued per frame and popped as each row is scanned.
module tb_pong_matrix_scanner;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_matrix_scanner_if #(.ROWS(8), .COLS(8)) bus();

  pong_matrix_scanner #(
    .ROWS(8), .COLS(8), .PADDLE_W(3), .DWELL(DWELL), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] bx;
    logic [3:0] by;
    logic [7:0] b0;
    logic [7:0] b7;
    int         rr;
    logic [7:0] rd;
    logic [7:0] gr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic set_inputs(input logic [3:0] p1, input logic [3:0] p2,
                            input logic [3:0] bx, input logic [3:0] by);
    bus.p1_pos = p1;
    bus.p2_pos = p2;
    bus.ball_x = bx;
    bus.ball_y = by;
  endtask

  task automatic do_reset();
    bus.frame_load = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_load();
    @(negedge clk);
    bus.frame_load = 1'b1;
    @(negedge clk);
    bus.frame_load = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 100);
    check("wait_frame_done", {31'b0, bus.frame_done}, 32'd1);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b7, input int rr,
                            input logic [7:0] rd, input logic [7:0] gr);
    logic [7:0] rs;
    for (int r = 0; r < 8; r++) begin
      rs = 8'(1 << r);
      exp_q.push_back({rs, (r == rr) ? rd : 8'h00, (r == rr) ? gr : 8'h00,
                       (r == 0) ? b0 : ((r == 7) ? b7 : 8'h00)});
    end
  endtask

  task automatic push_vec(input int i);
    push_frame(vecs[i].b0, vecs[i].b7, vecs[i].rr, vecs[i].rd, vecs[i].gr);
  endtask

  // Walks one frame starting from a blank cycle; optionally strobes frame_load
  // on scan cycle loadCyc of row loadRow with the inputs currently on the bus.
  task automatic capture_frame(input int loadRow, input int loadCyc);
    logic [31:0] cur;
    logic [31:0] exp;
    int n;
    for (int r = 0; r < 8; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        bus.frame_load = 1'b0;
        n++;
      end while (bus.row_sel == 8'h00 && n < 4);
      cur = {bus.row_sel, bus.red, bus.green, bus.blue};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty row%0d got=%08h exp=none", r, cur);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("row%0d", r), cur, exp);
      end
      n = 1;
      if (r == loadRow && n == loadCyc) bus.frame_load = 1'b1;
      while (n < 20) begin
        @(negedge clk);
        bus.frame_load = 1'b0;
        if ({bus.row_sel, bus.red, bus.green, bus.blue} != cur) break;
        n++;
        if (r == loadRow && n == loadCyc) bus.frame_load = 1'b1;
      end
      check($sformatf("dwell_row%0d", r), n, DWELL);
      check($sformatf("blank_row%0d", r), {bus.row_sel, bus.red, bus.green, bus.blue}, 32'h0);
      check($sformatf("frame_done_row%0d", r), {31'b0, bus.frame_done}, (r == 7) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{p1: 4'd0, p2: 4'd7, bx: 4'd3, by: 4'd4, b0: 8'h03, b7: 8'hC0, rr: 3,  rd: 8'h10, gr: 8'h00};
    vecs[1] = '{p1: 4'd1, p2: 4'd4, bx: 4'd0, by: 4'd1, b0: 8'h07, b7: 8'h38, rr: 0,  rd: 8'h02, gr: 8'h02};
    vecs[2] = '{p1: 4'd7, p2: 4'd8, bx: 4'd8, by: 4'd2, b0: 8'hC0, b7: 8'h00, rr: -1, rd: 8'h00, gr: 8'h00};
    vecs[3] = '{p1: 4'd8, p2: 4'd0, bx: 4'd7, by: 4'd0, b0: 8'h00, b7: 8'h03, rr: 7,  rd: 8'h01, gr: 8'h01};
    vecs[4] = '{p1: 4'd15, p2: 4'd3, bx: 4'd5, by: 4'd9, b0: 8'h00, b7: 8'h1C, rr: -1, rd: 8'h00, gr: 8'h00};
    vecs[5] = '{p1: 4'd4, p2: 4'd6, bx: 4'd15, by: 4'd15, b0: 8'h38, b7: 8'hE0, rr: -1, rd: 8'h00, gr: 8'h00};
    vecs[6] = '{p1: 4'd2, p2: 4'd2, bx: 4'd0, by: 4'd0, b0: 8'h0E, b7: 8'h0E, rr: 0,  rd: 8'h01, gr: 8'h00};

    bus.blink_en = 1'b0;
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0);
    do_reset();

    // Nothing loaded: empty scan with correct dwell, blanking and frame_done.
    push_frame(8'h00, 8'h00, -1, 8'h00, 8'h00);
    capture_frame(-1, 0);

    foreach (vecs[i]) begin
      set_inputs(vecs[i].p1, vecs[i].p2, vecs[i].bx, vecs[i].by);
      apply_load();
      wait_frame_done();
      push_vec(i);
      capture_frame(-1, 0);
    end

    // Load mid-frame during row 3: current frame keeps vector 6.
    set_inputs(vecs[0].p1, vecs[0].p2, vecs[0].bx, vecs[0].by);
    push_vec(6);
    capture_frame(3, 2);
    push_vec(0);
    capture_frame(-1, 0);

    // Load on the boundary edge: shows one frame later.
    set_inputs(vecs[1].p1, vecs[1].p2, vecs[1].bx, vecs[1].by);
    push_vec(0);
    capture_frame(7, DWELL);
    push_vec(0);
    capture_frame(-1, 0);
    push_vec(1);
    capture_frame(-1, 0);

    // Blink: counter equals frames since reset, ball hidden when (frame mod 4) >= 2.
    do_reset();
    bus.blink_en = 1'b1;
    set_inputs(4'd3, 4'd8, 4'd2, 4'd2);
    apply_load();
    wait_frame_done();
    for (int k = 1; k <= 5; k++) begin
      if ((k % 4) < 2) push_frame(8'h1C, 8'h00, 2, 8'h04, 8'h00);
      else             push_frame(8'h1C, 8'h00, -1, 8'h00, 8'h00);
      capture_frame(-1, 0);
    end
    bus.blink_en = 1'b0;

    // Asynchronous reset during row 5.
    n = 0;
    while (bus.row_sel != 8'h20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_row5", {24'b0, bus.row_sel}, 32'h20);
    #2 reset = 1'b1;
    #1 check("async_reset_pins", {bus.row_sel, bus.red, bus.green, bus.blue}, 32'h0);
    check("async_reset_frame_done", {31'b0, bus.frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_frame(8'h00, 8'h00, -1, 8'h00, 8'h00);
    capture_frame(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
